biquad_cascade_mc: RTL

// Multi-channel, runtime-programmable cascade of N_SECT biquad IIR sections in Direct Form I.
// It is the parametrised successor of the fixed two-section bandpass.
// One shared multiplier is time-multiplexed across taps, sections and channels.

---
 rtl/biquad_cascade_mc.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/biquad_cascade_mc.sv
// biquad_cascade_mc: multi-channel cascade of Direct Form I biquads sharing one multiplier
// Ports:
//   clk, rst                     clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready/in_ch/d_in sample input handshake, channel index and sample
//   out_valid/out_ch/d_out       one-cycle result pulse, channel and filtered sample (held between pulses)
//   bypass                       sampled at accept: pass d_in straight through, filter state untouched
//   flush                        while idle: clear all channel state and sat_flag, keep coefficients
//   coef_we/coef_addr/coef_data  coefficient write, addr = sect*5 + {b0,b1,b2,a1,a2}
//   coef_err                     one-cycle pulse when a coefficient write is dropped
//   sat_flag                     sticky flag: a section output was clipped
module biquad_cascade_mc #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 14,
    parameter int N_SECT    = 2,
    parameter int N_CH      = 2,
    parameter int ACC_W     = 40
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(N_CH)-1:0]     in_ch,
    input  logic signed [DATA_W-1:0]    d_in,
    output logic                        out_valid,
    output logic [$clog2(N_CH)-1:0]     out_ch,
    output logic signed [DATA_W-1:0]    d_out,
    input  logic                        bypass,
    input  logic                        flush,
    input  logic                        coef_we,
    input  logic [$clog2(5*N_SECT)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0]    coef_data,
    output logic                        coef_err,
    output logic                        sat_flag
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int CA_W  = $clog2(5 * N_SECT);
    localparam int SC_W  = (N_SECT > 1) ? $clog2(N_SECT) : 1;
    localparam int N_ST  = N_CH * N_SECT;
    localparam int IDX_W = (N_ST > 1) ? $clog2(N_ST) : 1;
    localparam int P_W   = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0]  HALF   = ACC_W'(1 << (COEF_FRAC - 1));
    localparam logic signed [ACC_W-1:0]  Y_MAX  = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0]  Y_MIN  = ACC_W'(-(1 << (DATA_W - 1)));
    localparam logic signed [COEF_W-1:0] B0_ONE = COEF_W'(1 << COEF_FRAC);

    typedef enum logic [1:0] {IDLE, MAC, WB, DONE} state_t;

    state_t                     state_q, state_d;
    logic [2:0]                 tap_q, tap_d;
    logic [SC_W-1:0]            sect_q, sect_d;
    logic [CH_W-1:0]            ch_q, ch_d, out_ch_q, out_ch_d;
    logic signed [DATA_W-1:0]   xc_q, xc_d, d_out_q, d_out_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       sat_q, sat_d, coef_err_q, coef_err_d;
    logic signed [COEF_W-1:0]   coef_q [5*N_SECT];
    logic signed [COEF_W-1:0]   coef_d [5*N_SECT];
    logic signed [DATA_W-1:0]   x1_q [N_ST], x1_d [N_ST], x2_q [N_ST], x2_d [N_ST];
    logic signed [DATA_W-1:0]   y1_q [N_ST], y1_d [N_ST], y2_q [N_ST], y2_d [N_ST];

    logic                       idle, coef_ok, clip_hi, clip_lo;
    logic [IDX_W-1:0]           st_idx;
    logic [CA_W-1:0]            c_idx;
    logic signed [COEF_W-1:0]   coef_sel;
    logic signed [DATA_W-1:0]   data_sel, y_sat;
    logic signed [P_W-1:0]      prod;
    logic signed [ACC_W-1:0]    pe, y_full;

    assign idle      = (state_q == IDLE) || (state_q == DONE);
    assign in_ready  = idle && !flush;
    assign out_valid = state_q == DONE;
    assign coef_ok   = coef_we && in_ready && (int'(coef_addr) < 5 * N_SECT);
    assign out_ch    = out_ch_q;
    assign d_out     = d_out_q;
    assign coef_err  = coef_err_q;
    assign sat_flag  = sat_q;

    // The single multiplier: tap_q picks which coefficient/history pair feeds it this cycle.
    assign st_idx   = IDX_W'(int'(ch_q) * N_SECT + int'(sect_q));
    assign c_idx    = CA_W'(int'(sect_q) * 5 + int'(tap_q));
    assign coef_sel = coef_q[c_idx];
    assign data_sel = (tap_q == 3'd0) ? xc_q :
                      (tap_q == 3'd1) ? x1_q[st_idx] :
                      (tap_q == 3'd2) ? x2_q[st_idx] :
                      (tap_q == 3'd3) ? y1_q[st_idx] : y2_q[st_idx];
    assign prod     = coef_sel * data_sel;
    assign pe       = {{(ACC_W - P_W){prod[P_W-1]}}, prod};

    // Round half up, then clip to the sample range.
    assign y_full  = (acc_q + HALF) >>> COEF_FRAC;
    assign clip_hi = y_full > Y_MAX;
    assign clip_lo = y_full < Y_MIN;
    assign y_sat   = clip_hi ? DATA_W'(Y_MAX) : clip_lo ? DATA_W'(Y_MIN) : DATA_W'(y_full);

    always_comb begin
        state_d    = state_q;
        tap_d      = tap_q;
        sect_d     = sect_q;
        ch_d       = ch_q;
        xc_d       = xc_q;
        acc_d      = acc_q;
        d_out_d    = d_out_q;
        out_ch_d   = out_ch_q;
        sat_d      = sat_q;
        coef_err_d = coef_we && !coef_ok;
        coef_d     = coef_q;
        x1_d       = x1_q;
        x2_d       = x2_q;
        y1_d       = y1_q;
        y2_d       = y2_q;
        if (coef_ok)
            coef_d[coef_addr] = coef_data;
        if (idle) begin
            state_d = IDLE;
            if (flush) begin
                sat_d = 1'b0;
                for (int i = 0; i < N_ST; i++) begin
                    x1_d[i] = '0;
                    x2_d[i] = '0;
                    y1_d[i] = '0;
                    y2_d[i] = '0;
                end
            end else if (in_valid && (int'(in_ch) < N_CH)) begin
                ch_d   = in_ch;
                xc_d   = d_in;
                sect_d = '0;
                tap_d  = '0;
                if (bypass) begin
                    state_d  = DONE;
                    d_out_d  = d_in;
                    out_ch_d = in_ch;
                end else begin
                    state_d = MAC;
                end
            end
        end else if (state_q == MAC) begin
            // Tap 0 restarts the accumulator; feedback taps are subtracted.
            acc_d = ((tap_q == 3'd0) ? '0 : acc_q) + ((tap_q >= 3'd3) ? -pe : pe);
            tap_d = (tap_q == 3'd4) ? 3'd0 : tap_q + 3'd1;
            if (tap_q == 3'd4)
                state_d = WB;
        end else begin
            x2_d[st_idx] = x1_q[st_idx];
            x1_d[st_idx] = xc_q;
            y2_d[st_idx] = y1_q[st_idx];
            y1_d[st_idx] = y_sat;
            xc_d         = y_sat;
            sat_d        = sat_q || clip_hi || clip_lo;
            if (int'(sect_q) == N_SECT - 1) begin
                state_d  = DONE;
                d_out_d  = y_sat;
                out_ch_d = ch_q;
            end else begin
                sect_d  = sect_q + SC_W'(1);
                state_d = MAC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tap_q      <= '0;
            sect_q     <= '0;
            ch_q       <= '0;
            xc_q       <= '0;
            acc_q      <= '0;
            d_out_q    <= '0;
            out_ch_q   <= '0;
            sat_q      <= 1'b0;
            coef_err_q <= 1'b0;
            for (int i = 0; i < 5 * N_SECT; i++)
                coef_q[i] <= (i % 5 == 0) ? B0_ONE : '0;
            for (int i = 0; i < N_ST; i++) begin
                x1_q[i] <= '0;
                x2_q[i] <= '0;
                y1_q[i] <= '0;
                y2_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            tap_q      <= tap_d;
            sect_q     <= sect_d;
            ch_q       <= ch_d;
            xc_q       <= xc_d;
            acc_q      <= acc_d;
            d_out_q    <= d_out_d;
            out_ch_q   <= out_ch_d;
            sat_q      <= sat_d;
            coef_err_q <= coef_err_d;
            coef_q     <= coef_d;
            x1_q       <= x1_d;
            x2_q       <= x2_d;
            y1_q       <= y1_d;
            y2_q       <= y2_d;
        end
    end
endmodule
